// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit and its return stack.
package ctrl_pkg;

  // Control FSM states; HALT and FAULT are left only by reset.
  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StMemWait,
    StHalt,
    StFault
  } state_e;

  // PC-select encodings driven on PS.
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_RET  = 2'b11;

  // Low three opcode bits of a control/memory class instruction (MSB set).
  localparam logic [2:0] OP_LI   = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BZ   = 3'b011;
  localparam logic [2:0] OP_BNZ  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b111;

  // End-of-execution value that turns OP_RET into a halt.
  localparam logic [3:0] EOE_HALT = 4'hF;

endpackage

// File: rtl/ret_stack.sv
// Pointer-based LIFO of return addresses. top reads 0 while empty; a push when
// full or a pop when empty is ignored. The controller never pushes and pops together.
module ret_stack #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  // Pointer counts occupied entries, so it needs to reach STACK_DEPTH itself.
  localparam int unsigned PtrW = $clog2(STACK_DEPTH + 1);

  logic [PtrW-1:0] ptr_q;
  logic [PC_W-1:0] mem_q [STACK_DEPTH];

  assign full  = (ptr_q == PtrW'(STACK_DEPTH));
  assign empty = (ptr_q == '0);

  // Occupancy pointer with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (push && !full) begin
      ptr_q <= ptr_q + PtrW'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PtrW'(1);
    end
  end

  // Entry storage; contents are meaningless above the pointer so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (PtrW'(i) == ptr_q) begin
          mem_q[i] <= din;
        end
      end
    end
  end

  // Top-of-stack read: the entry just below the pointer, or 0 when empty.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (!empty && (PtrW'(i + 1) == ptr_q)) begin
        top = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control unit: fetch/execute FSM, return stack for call/return,
// variable-latency memory handshake, sticky halt and fault.
// Optional feature macro: CTRL_PERF_CNT_EN adds the 32-bit retired-instruction counter.
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned FS_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [FS_W-1:0] opcode,
  input  logic            Z,
  input  logic [3:0]      eoe,
  input  logic [PC_W-1:0] pc,
  input  logic            mem_ready,
  output logic [1:0]      PS,
  output logic            IL,
  output logic            MB,
  output logic [FS_W-1:0] FS,
  output logic            MD,
  output logic            RW,
  output logic            MW,
  output logic            MP,
  output logic            mem_req,
  output logic [PC_W-1:0] ret_addr,
  output logic            halted,
  output logic            fault
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     retired
`endif
);

  state_e          state_q, state_d;
  logic            push, pop;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] ret_din;
  logic [2:0]      sub_op;

  assign sub_op  = opcode[2:0];
  assign ret_din = pc + PC_W'(1);
  assign FS      = opcode;

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ret_din),
    .top   (ret_addr),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // State register; the only FSM storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode from state plus current inputs.
  always_comb begin
    state_d = state_q;
    PS      = PS_HOLD;
    IL      = 1'b0;
    MB      = 1'b0;
    MD      = 1'b0;
    RW      = 1'b0;
    MW      = 1'b0;
    MP      = 1'b0;
    mem_req = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StFetch: begin
        IL      = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        if (!opcode[FS_W-1]) begin
          PS = PS_INC;
          RW = 1'b1;
        end else begin
          unique case (sub_op)
            OP_LI: begin
              MB = 1'b1;
              RW = 1'b1;
              PS = PS_INC;
            end
            OP_LW: begin
              mem_req = 1'b1;
              MD      = 1'b1;
              if (mem_ready) begin
                RW = 1'b1;
                PS = PS_INC;
              end else begin
                state_d = StMemWait;
              end
            end
            OP_SW: begin
              mem_req = 1'b1;
              MW      = 1'b1;
              if (mem_ready) begin
                PS = PS_INC;
              end else begin
                state_d = StMemWait;
              end
            end
            OP_BZ:  PS = Z ? PS_BR : PS_INC;
            OP_BNZ: PS = Z ? PS_INC : PS_BR;
            OP_CALL: begin
              if (stk_full) begin
                state_d = StFault;
              end else begin
                RW   = 1'b1;
                MP   = 1'b1;
                PS   = PS_BR;
                push = 1'b1;
              end
            end
            OP_JMP: PS = PS_BR;
            OP_RET: begin
              if (eoe == EOE_HALT) begin
                state_d = StHalt;
              end else if (stk_empty) begin
                state_d = StFault;
              end else begin
                PS  = PS_RET;
                pop = 1'b1;
              end
            end
            default: state_d = StFetch;
          endcase
        end
      end
      StMemWait: begin
        // The instruction register is frozen (IL=0), so the opcode still names the access.
        mem_req = 1'b1;
        if (sub_op == OP_SW) begin
          MW = 1'b1;
        end else begin
          MD = 1'b1;
        end
        if (mem_ready) begin
          RW      = (sub_op != OP_SW);
          PS      = PS_INC;
          state_d = StFetch;
        end
      end
      StHalt:  halted = 1'b1;
      StFault: fault  = 1'b1;
      default: state_d = StFetch;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q;
  logic        complete;

  assign complete = ((state_q == StExec) || (state_q == StMemWait)) && (state_d == StFetch);
  assign retired  = retired_q;

  // Count instructions that finish and return to fetch; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (complete) begin
      retired_q <= retired_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench for multicycle_ctrl_unit: the stimulus process pushes the
// hand-computed control vector for each checked cycle; a monitor pops and compares.
module tb_multicycle_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       z;
  logic [3:0] eoe;
  logic [7:0] pc;
  logic       mem_ready;
  logic [1:0] ps;
  logic       il, mb, md, rw, mw, mp, mem_req, halted, fault;
  logic [3:0] fs;
  logic [7:0] ret_addr;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_unit #(
    .PC_W        (8),
    .STACK_DEPTH (4),
    .FS_W        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .Z         (z),
    .eoe       (eoe),
    .pc        (pc),
    .mem_ready (mem_ready),
    .PS        (ps),
    .IL        (il),
    .MB        (mb),
    .FS        (fs),
    .MD        (md),
    .RW        (rw),
    .MW        (mw),
    .MP        (mp),
    .mem_req   (mem_req),
    .ret_addr  (ret_addr),
    .halted    (halted),
    .fault     (fault)
`ifdef CTRL_PERF_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  // Expected PS values.
  localparam logic [1:0] HOLD = 2'b00, INC = 2'b01, BR = 2'b10, RET = 2'b11;
  // Control bit masks, order {IL, MB, MD, RW, MW, MP, mem_req}.
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_IL   = 7'b1000000;
  localparam logic [6:0] C_MB   = 7'b0100000;
  localparam logic [6:0] C_MD   = 7'b0010000;
  localparam logic [6:0] C_RW   = 7'b0001000;
  localparam logic [6:0] C_MW   = 7'b0000100;
  localparam logic [6:0] C_MP   = 7'b0000010;
  localparam logic [6:0] C_MRQ  = 7'b0000001;
  // {halted, fault}
  localparam logic [1:0] HF_NONE = 2'b00, HF_HALT = 2'b10, HF_FAULT = 2'b01;

  typedef struct packed {
    logic [1:0] ps;
    logic [6:0] ctl;
    logic [7:0] ra;
    logic [1:0] hf;
    logic [3:0] fs;
  } ctl_t;

  typedef struct {
    string       name;
    ctl_t        exp;
    logic        chk_ret;
    logic [31:0] ret;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_ret_next = 1'b0;
  logic [31:0] ret_next = '0;

  // Monitor: compare one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      ctl_t      act;
      e   = sb.pop_front();
      act = '{ps: ps, ctl: {il, mb, md, rw, mw, mp, mem_req}, ra: ret_addr,
              hf: {halted, fault}, fs: fs};
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got ps=%b ctl=%b ra=%h hf=%b fs=%h, want ps=%b ctl=%b ra=%h hf=%b fs=%h",
                 e.name, act.ps, act.ctl, act.ra, act.hf, act.fs,
                 e.exp.ps, e.exp.ctl, e.exp.ra, e.exp.hf, e.exp.fs);
      end
`ifdef CTRL_PERF_CNT_EN
      if (e.chk_ret) begin
        n_cmp++;
        if (retired !== e.ret) begin
          n_bad++;
          $display("FAIL %s_retired: got %0d want %0d", e.name, retired, e.ret);
        end
      end
`endif
    end
  end

  // Drive one cycle of inputs, queue its expected controls, advance to just past the edge.
  task automatic cyc(input string nm, input logic [3:0] op, input logic zz, input logic [3:0] ee,
                     input logic [7:0] p, input logic mr, input logic [1:0] eps,
                     input logic [6:0] ectl, input logic [7:0] era, input logic [1:0] ehf);
    sb_entry_t e;
    opcode    = op;
    z         = zz;
    eoe       = ee;
    pc        = p;
    mem_ready = mr;
    e.name    = nm;
    e.exp     = '{ps: eps, ctl: ectl, ra: era, hf: ehf, fs: op};
    e.chk_ret = chk_ret_next;
    e.ret     = ret_next;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Unchecked cycle.
  task automatic skip();
    opcode    = 4'h0;
    z         = 1'b0;
    eoe       = 4'h0;
    pc        = 8'h00;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reset from any state: one unchecked cycle with rst_n low, then check FETCH.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    skip();
    cyc(nm, 4'h0, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    skip();
    cyc("reset_state", 4'h0, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    rst_n = 1'b1;

    // ALU op
    cyc("alu_fetch", 4'h3, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("alu_exec",  4'h3, 0, 0, 8'h00, 0, INC,  C_RW, 8'h00, HF_NONE);

    // Load word, three wait cycles
    cyc("lw_fetch", 4'h9, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("lw_exec",  4'h9, 0, 0, 8'h00, 0, HOLD, C_MRQ | C_MD, 8'h00, HF_NONE);
    cyc("lw_wait1", 4'h9, 0, 0, 8'h00, 0, HOLD, C_MRQ | C_MD, 8'h00, HF_NONE);
    cyc("lw_wait2", 4'h9, 0, 0, 8'h00, 0, HOLD, C_MRQ | C_MD, 8'h00, HF_NONE);
    cyc("lw_done",  4'h9, 0, 0, 8'h00, 1, INC,  C_MRQ | C_MD | C_RW, 8'h00, HF_NONE);

    // Store word: immediate completion, then one wait
    cyc("sw_fetch",  4'hA, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("sw_fast",   4'hA, 0, 0, 8'h00, 1, INC,  C_MRQ | C_MW, 8'h00, HF_NONE);
    cyc("sw_fetch2", 4'hA, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("sw_exec",   4'hA, 0, 0, 8'h00, 0, HOLD, C_MRQ | C_MW, 8'h00, HF_NONE);
    cyc("sw_done",   4'hA, 0, 0, 8'h00, 1, INC,  C_MRQ | C_MW, 8'h00, HF_NONE);

    // Load immediate, branches, jump
    cyc("li_fetch",  4'h8, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("li_exec",   4'h8, 0, 0, 8'h00, 0, INC,  C_MB | C_RW, 8'h00, HF_NONE);
    cyc("bz_fetch",  4'hB, 1, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("bz_z1",     4'hB, 1, 0, 8'h00, 0, BR,   C_NONE, 8'h00, HF_NONE);
    cyc("bz_fetch2", 4'hB, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("bz_z0",     4'hB, 0, 0, 8'h00, 0, INC,  C_NONE, 8'h00, HF_NONE);
    cyc("bnz_fetch", 4'hC, 1, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("bnz_z1",    4'hC, 1, 0, 8'h00, 0, INC,  C_NONE, 8'h00, HF_NONE);
    cyc("bnz_fetch2",4'hC, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("bnz_z0",    4'hC, 0, 0, 8'h00, 0, BR,   C_NONE, 8'h00, HF_NONE);
    cyc("jmp_fetch", 4'hE, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("jmp_exec",  4'hE, 0, 0, 8'h00, 0, BR,   C_NONE, 8'h00, HF_NONE);

    // Nested call/return
    cyc("call1_fetch", 4'hD, 0, 0, 8'h10, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("call1_exec",  4'hD, 0, 0, 8'h10, 0, BR,   C_RW | C_MP, 8'h00, HF_NONE);
    cyc("call2_fetch", 4'hD, 0, 0, 8'h20, 0, HOLD, C_IL, 8'h11, HF_NONE);
    cyc("call2_exec",  4'hD, 0, 0, 8'h20, 0, BR,   C_RW | C_MP, 8'h11, HF_NONE);
    cyc("ret1_fetch",  4'hF, 0, 0, 8'h30, 0, HOLD, C_IL, 8'h21, HF_NONE);
    cyc("ret1_exec",   4'hF, 0, 0, 8'h30, 0, RET,  C_NONE, 8'h21, HF_NONE);
    cyc("ret2_fetch",  4'hF, 0, 0, 8'h21, 0, HOLD, C_IL, 8'h11, HF_NONE);
    cyc("ret2_exec",   4'hF, 0, 0, 8'h21, 0, RET,  C_NONE, 8'h11, HF_NONE);
    cyc("stack_empty", 4'h0, 0, 0, 8'h11, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("nop_exec",    4'h0, 0, 0, 8'h11, 0, INC,  C_RW, 8'h00, HF_NONE);

    // Fill the stack, then overflow
    cyc("fill1_fetch", 4'hD, 0, 0, 8'h30, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("fill1_exec",  4'hD, 0, 0, 8'h30, 0, BR,   C_RW | C_MP, 8'h00, HF_NONE);
    cyc("fill2_fetch", 4'hD, 0, 0, 8'h31, 0, HOLD, C_IL, 8'h31, HF_NONE);
    cyc("fill2_exec",  4'hD, 0, 0, 8'h31, 0, BR,   C_RW | C_MP, 8'h31, HF_NONE);
    cyc("fill3_fetch", 4'hD, 0, 0, 8'h32, 0, HOLD, C_IL, 8'h32, HF_NONE);
    cyc("fill3_exec",  4'hD, 0, 0, 8'h32, 0, BR,   C_RW | C_MP, 8'h32, HF_NONE);
    cyc("fill4_fetch", 4'hD, 0, 0, 8'h33, 0, HOLD, C_IL, 8'h33, HF_NONE);
    cyc("fill4_exec",  4'hD, 0, 0, 8'h33, 0, BR,   C_RW | C_MP, 8'h33, HF_NONE);
    cyc("ovf_fetch",   4'hD, 0, 0, 8'h40, 0, HOLD, C_IL, 8'h34, HF_NONE);
    cyc("ovf_exec",    4'hD, 0, 0, 8'h40, 0, HOLD, C_NONE, 8'h34, HF_NONE);
    cyc("ovf_fault1",  4'h3, 0, 0, 8'h40, 1, HOLD, C_NONE, 8'h34, HF_FAULT);
    cyc("ovf_fault2",  4'hF, 1, 0, 8'h40, 1, HOLD, C_NONE, 8'h34, HF_FAULT);
    cyc("ovf_fault3",  4'h9, 0, 0, 8'h40, 1, HOLD, C_NONE, 8'h34, HF_FAULT);
    do_reset("ovf_reset");

    // Return on an empty stack
    cyc("unf_fetch",  4'hF, 0, 0, 8'h50, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("unf_exec",   4'hF, 0, 0, 8'h50, 0, HOLD, C_NONE, 8'h00, HF_NONE);
    cyc("unf_fault1", 4'hD, 0, 0, 8'h50, 0, HOLD, C_NONE, 8'h00, HF_FAULT);
    cyc("unf_fault2", 4'h0, 0, 0, 8'h50, 0, HOLD, C_NONE, 8'h00, HF_FAULT);
    do_reset("unf_reset");

    // Three completed instructions, then halt
    cyc("h_alu_fetch", 4'h5, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("h_alu_exec",  4'h5, 0, 0, 8'h00, 0, INC,  C_RW, 8'h00, HF_NONE);
    cyc("h_li_fetch",  4'h8, 0, 0, 8'h01, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("h_li_exec",   4'h8, 0, 0, 8'h01, 0, INC,  C_MB | C_RW, 8'h00, HF_NONE);
    cyc("h_bz_fetch",  4'hB, 1, 0, 8'h02, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("h_bz_exec",   4'hB, 1, 0, 8'h02, 0, BR,   C_NONE, 8'h00, HF_NONE);
    cyc("halt_fetch",  4'hF, 0, 4'hF, 8'h03, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("halt_exec",   4'hF, 0, 4'hF, 8'h03, 0, HOLD, C_NONE, 8'h00, HF_NONE);
    chk_ret_next = 1'b1;
    ret_next     = 32'd3;
    cyc("halted1", 4'h3, 0, 0, 8'h03, 1, HOLD, C_NONE, 8'h00, HF_HALT);
    cyc("halted2", 4'hD, 0, 0, 8'h03, 1, HOLD, C_NONE, 8'h00, HF_HALT);
    cyc("halted3", 4'h9, 1, 0, 8'h03, 1, HOLD, C_NONE, 8'h00, HF_HALT);
    chk_ret_next = 1'b0;
    do_reset("halt_reset");

    // Reset during a memory wait abandons the access
    cyc("mr_fetch", 4'h9, 0, 0, 8'h00, 0, HOLD, C_IL, 8'h00, HF_NONE);
    cyc("mr_exec",  4'h9, 0, 0, 8'h00, 0, HOLD, C_MRQ | C_MD, 8'h00, HF_NONE);
    cyc("mr_wait",  4'h9, 0, 0, 8'h00, 0, HOLD, C_MRQ | C_MD, 8'h00, HF_NONE);
    chk_ret_next = 1'b1;
    ret_next     = 32'd0;
    do_reset("mr_reset");
    chk_ret_next = 1'b0;

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
